// File: rtl/game_over_pkg.sv
// Shared types and constants for the game-over sprite sequencer.
// Screen geometry sets the default sprite placement: centred in X, resting mid-screen in Y.
package game_over_pkg;

  localparam int COORD_W     = 11;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int SPRITE_SIZE = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DROP     = 3'd1,
    ST_BLINK    = 3'd2,
    ST_WAIT_KEY = 3'd3,
    ST_RESTART  = 3'd4
  } state_e;

  // Counter width for a counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_rise_detect.sv
// Single-cycle press pulse from an already-synchronised key level.
// The previous-value register runs every cycle so a held key never re-triggers.
module key_rise_detect (
  input  logic clk,
  input  logic resetN,
  input  logic key_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= key_i;
    end
  end

  assign rise_o = key_i & ~prev_q;

endmodule

// File: rtl/game_over_ctrl.sv
// Game-over sprite sequencer: freeze, drop the bitmap, optionally blink, wait for a fresh key press.
// The blink phase is compiled in only when GAME_OVER_BLINK_EN is defined.
import game_over_pkg::*;

module game_over_ctrl #(
  parameter int START_X       = (SCREEN_W - SPRITE_SIZE) / 2,
  parameter int START_Y       = 0,
  parameter int TARGET_Y      = (SCREEN_H - SPRITE_SIZE) / 2,
  parameter int DROP_SPEED    = 4,
  parameter int BLINK_FRAMES  = 15,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               playerDead,
  input  logic               restartKey,
  output logic [COORD_W-1:0] topLeftX,
  output logic [COORD_W-1:0] topLeftY,
  output logic               show,
  output logic               gameFreeze,
  output logic               restartReq
);

  // Handshake-free block: playerDead is a level/pulse qualified by IDLE, startOfFrame is a
  // single-cycle strobe, and restartReq is a single-cycle strobe the game logic must not stall.

  state_e             state_q, state_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               show_q, show_d;
  logic               freeze_q, freeze_d;
  logic               req_q, req_d;
  logic               key_rise;

  // One extra bit keeps the drop sum from wrapping before the clamp compare.
  logic [COORD_W:0]   y_sum;
  logic               drop_done;

  assign y_sum     = {1'b0, y_q} + (COORD_W + 1)'(DROP_SPEED);
  assign drop_done = (y_sum >= (COORD_W + 1)'(TARGET_Y));

`ifdef GAME_OVER_BLINK_EN
  localparam int FRAME_W  = cnt_width(BLINK_FRAMES);
  localparam int TOGGLE_W = cnt_width(BLINK_TOGGLES + 1);

  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [TOGGLE_W-1:0] toggle_q, toggle_d;
  logic                frame_wrap;
  logic                blink_done;

  assign frame_wrap = (frame_q == FRAME_W'(BLINK_FRAMES - 1));
  assign blink_done = frame_wrap && (toggle_q == TOGGLE_W'(BLINK_TOGGLES - 1));
`endif

  key_rise_detect u_key_rise (
    .clk    (clk),
    .resetN (resetN),
    .key_i  (restartKey),
    .rise_o (key_rise)
  );

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      y_q      <= COORD_W'(START_Y);
      show_q   <= 1'b0;
      freeze_q <= 1'b0;
      req_q    <= 1'b0;
`ifdef GAME_OVER_BLINK_EN
      frame_q  <= '0;
      toggle_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      show_q   <= show_d;
      freeze_q <= freeze_d;
      req_q    <= req_d;
`ifdef GAME_OVER_BLINK_EN
      frame_q  <= frame_d;
      toggle_q <= toggle_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (playerDead) state_d = ST_DROP;
      end
      ST_DROP: begin
        if (startOfFrame && drop_done) begin
`ifdef GAME_OVER_BLINK_EN
          state_d = ST_BLINK;
`else
          state_d = ST_WAIT_KEY;
`endif
        end
      end
`ifdef GAME_OVER_BLINK_EN
      ST_BLINK: begin
        if (startOfFrame && blink_done) state_d = ST_WAIT_KEY;
      end
`endif
      ST_WAIT_KEY: begin
        if (key_rise) state_d = ST_RESTART;
      end
      ST_RESTART: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    y_d      = y_q;
    show_d   = show_q;
    freeze_d = freeze_q;
    req_d    = 1'b0;
`ifdef GAME_OVER_BLINK_EN
    frame_d  = frame_q;
    toggle_d = toggle_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (playerDead) begin
          show_d   = 1'b1;
          freeze_d = 1'b1;
          y_d      = COORD_W'(START_Y);
        end
      end
      ST_DROP: begin
        if (startOfFrame) begin
          y_d = drop_done ? COORD_W'(TARGET_Y) : y_sum[COORD_W-1:0];
`ifdef GAME_OVER_BLINK_EN
          if (drop_done) begin
            frame_d  = '0;
            toggle_d = '0;
          end
`endif
        end
      end
`ifdef GAME_OVER_BLINK_EN
      ST_BLINK: begin
        if (startOfFrame) begin
          if (frame_wrap) begin
            show_d   = ~show_q;
            frame_d  = '0;
            toggle_d = toggle_q + 1'b1;
          end else begin
            frame_d  = frame_q + 1'b1;
          end
        end
      end
`endif
      ST_WAIT_KEY: begin
        show_d = 1'b1;
        if (key_rise) req_d = 1'b1;
      end
      ST_RESTART: begin
        show_d   = 1'b0;
        freeze_d = 1'b0;
        y_d      = COORD_W'(START_Y);
      end
      default: begin
        show_d   = 1'b0;
        freeze_d = 1'b0;
        y_d      = COORD_W'(START_Y);
      end
    endcase
  end

  // X never moves, so a constant drive is as glitch-free as a register.
  assign topLeftX   = COORD_W'(START_X);
  assign topLeftY   = y_q;
  assign show       = show_q;
  assign gameFreeze = freeze_q;
  assign restartReq = req_q;

endmodule

// File: tb/tb_game_over_ctrl.sv
// Directed bench for game_over_ctrl: default-parameter instance plus a DROP_SPEED=5 instance for the clamp.
// Expectations follow GAME_OVER_BLINK_EN the same way the design does.
import game_over_pkg::*;

module tb_game_over_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        sof;
  logic        pd;
  logic        key;
  logic [10:0] top_x, top_y, top_x5, top_y5;
  logic        show, freeze, req;
  logic        show5, freeze5, req5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  game_over_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (sof),
    .playerDead   (pd),
    .restartKey   (key),
    .topLeftX     (top_x),
    .topLeftY     (top_y),
    .show         (show),
    .gameFreeze   (freeze),
    .restartReq   (req)
  );

  game_over_ctrl #(.DROP_SPEED(5)) dut5 (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (sof),
    .playerDead   (pd),
    .restartKey   (key),
    .topLeftX     (top_x5),
    .topLeftY     (top_y5),
    .show         (show5),
    .gameFreeze   (freeze5),
    .restartReq   (req5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_y"},      32'(top_y),         32'd0);
    check({tag, "_x"},      32'(top_x),         32'd304);
    check({tag, "_show"},   32'(show),          32'd0);
    check({tag, "_freeze"}, 32'(freeze),        32'd0);
    check({tag, "_req"},    32'(req),           32'd0);
    check({tag, "_state"},  32'(dut.state_q),   32'(ST_IDLE));
  endtask

  logic [31:0] drop_end_state;
  logic [31:0] pre_reset_show;

  initial begin
`ifdef GAME_OVER_BLINK_EN
    drop_end_state = 32'(ST_BLINK);
    pre_reset_show = 32'd0;
`else
    drop_end_state = 32'(ST_WAIT_KEY);
    pre_reset_show = 32'd1;
`endif
    resetN = 1'b0;
    sof    = 1'b0;
    pd     = 1'b0;
    key    = 1'b0;
    repeat (3) tick();
    check_reset_values("rst");

    resetN = 1'b1;
    tick();
    frame();
    check("idle_sof_y",     32'(top_y),       32'd0);
    check("idle_sof_show",  32'(show),        32'd0);
    check("idle_sof_state", 32'(dut.state_q), 32'(ST_IDLE));

    pd = 1'b1;
    tick();
    pd = 1'b0;
    check("dead_show",   32'(show),        32'd1);
    check("dead_freeze", 32'(freeze),      32'd1);
    check("dead_y",      32'(top_y),       32'd0);
    check("dead_state",  32'(dut.state_q), 32'(ST_DROP));

    // Key goes down during the drop and stays down through WAIT_KEY entry.
    for (int k = 1; k <= 56; k++) begin
      if (k == 50) key = 1'b1;
      frame();
      check("drop_y", 32'(top_y), 32'(4 * k));
      if (k <= 49) check("clamp_y", 32'(top_y5), (5 * k < 224) ? 32'(5 * k) : 32'd224);
      if (k == 55) check("drop_state_55", 32'(dut.state_q), 32'(ST_DROP));
      if (k == 44) check("clamp_state_44", 32'(dut5.state_q), 32'(ST_DROP));
    end
    check("drop_end_state",  32'(dut.state_q), drop_end_state);
    check("drop_end_freeze", 32'(freeze),      32'd1);

`ifdef GAME_OVER_BLINK_EN
    for (int f = 1; f <= 90; f++) begin
      frame();
      check("blink_show", 32'(show), ((f / 15) % 2 == 0) ? 32'd1 : 32'd0);
      if (f < 90) check("blink_state", 32'(dut.state_q), 32'(ST_BLINK));
    end
`else
    for (int f = 1; f <= 20; f++) begin
      frame();
      check("nb_show", 32'(show), 32'd1);
      check("nb_y",    32'(top_y), 32'd224);
    end
`endif
    check("wait_state", 32'(dut.state_q), 32'(ST_WAIT_KEY));
    check("wait_show",  32'(show),        32'd1);

    repeat (5) begin
      tick();
      check("held_req", 32'(req), 32'd0);
    end
    check("held_state", 32'(dut.state_q), 32'(ST_WAIT_KEY));

    key = 1'b0;
    tick();
    check("release_req", 32'(req), 32'd0);
    key = 1'b1;
    tick();
    check("press_req",    32'(req),         32'd1);
    check("press_state",  32'(dut.state_q), 32'(ST_RESTART));
    check("press_freeze", 32'(freeze),      32'd1);
    tick();
    check("after_req",    32'(req),         32'd0);
    check("after_state",  32'(dut.state_q), 32'(ST_IDLE));
    check("after_show",   32'(show),        32'd0);
    check("after_freeze", 32'(freeze),      32'd0);
    check("after_y",      32'(top_y),       32'd0);
    tick();
    check("still_no_req", 32'(req), 32'd0);
    key = 1'b0;

    pd = 1'b1;
    tick();
    pd = 1'b0;
    repeat (56) frame();
    repeat (20) frame();
    check("pre_reset_state", 32'(dut.state_q), drop_end_state);
    check("pre_reset_show",  32'(show),        pre_reset_show);
    resetN = 1'b0;
    tick();
    check_reset_values("mid_rst");
    check("mid_rst_y5", 32'(top_y5), 32'd0);
    resetN = 1'b1;
    frame();
    check("post_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("post_rst_show",  32'(show),        32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_over_ctrl.md
# game_over_ctrl

Sequencer for the game-over sprite. Registers a player-death event and freezes gameplay. Drops the 32x32 game-over bitmap from the top of the screen to its resting row, optionally blinks it, then waits for a fresh restart key press. It drives the sprite's top-left position and visibility into the square-object/bitmap path, and issues a one-cycle restart request to the game logic.

## Interface

Parameters:
- START_X, 304, fixed sprite X (horizontally centred on 640).
- START_Y, 0, sprite Y at the start of the drop.
- TARGET_Y, 224, resting Y; must satisfy TARGET_Y ≥ START_Y.
- DROP_SPEED, 4, pixels moved per frame during the drop; must be ≥ 1.
- BLINK_FRAMES, 15, frames per blink half-period; must be ≥ 1.
- BLINK_TOGGLES, 6, visibility toggles in the blink phase; must be even and ≥ 2.

Ports:
- clk, in, 1, system clock.
- resetN, in, 1, reset. **Synchronous, active-low.**
- startOfFrame, in, 1, one-cycle pulse per video frame.
- playerDead, in, 1, level or pulse; sampled only in IDLE.
- restartKey, in, 1, raw key level, already synchronised.
- topLeftX, out, 11, sprite X (signed 11-bit).
- topLeftY, out, 11, sprite Y (signed 11-bit).
- show, out, 1, sprite visible; gates the bitmap's InsideRectangle.
- gameFreeze, out, 1, high while the game-over sequence runs.
- restartReq, out, 1, one-cycle restart pulse.

## Operation

- All outputs are registered.
- Reset values: topLeftX = START_X, topLeftY = START_Y, show = 0, gameFreeze = 0, restartReq = 0, state = IDLE, all counters = 0.
- States: IDLE, DROP, BLINK, WAIT_KEY, RESTART.
- IDLE:
  - playerDead = 1 -> go to DROP.
  - On that transition: show = 1, gameFreeze = 1, topLeftY = START_Y.
- DROP, on each startOfFrame:
  - topLeftY = min(topLeftY + DROP_SPEED, TARGET_Y). Compute the sum in 12 bits so it cannot wrap.
  - When the new value equals TARGET_Y -> go to BLINK; frameCnt and toggleCnt = 0.
  - If START_Y == TARGET_Y, the first startOfFrame in DROP moves directly to BLINK.
- BLINK, on each startOfFrame:
  - If frameCnt == BLINK_FRAMES-1: toggle show, set frameCnt = 0, increment toggleCnt.
  - Otherwise increment frameCnt.
  - When toggleCnt reaches BLINK_TOGGLES -> go to WAIT_KEY. show = 1 at that point, because the toggle count is even.
- WAIT_KEY:
  - show = 1.
  - A rising edge of restartKey (current = 1, previous = 0) -> go to RESTART.
  - A key already held when WAIT_KEY is entered is ignored until it is released and pressed again.
  - The edge detector's previous-value register updates every cycle in every state.
- RESTART, lasts exactly one cycle:
  - restartReq = 1.
  - Next cycle: state = IDLE, restartReq = 0, show = 0, gameFreeze = 0, topLeftY = START_Y.
- playerDead is ignored outside IDLE.
- restartKey is ignored outside WAIT_KEY.
- startOfFrame has no effect in IDLE, WAIT_KEY or RESTART.
- topLeftX is constant at START_X.

## Timing

- playerDead sampled in cycle N -> show and gameFreeze are high in cycle N+1.
- The position update lands one cycle after the startOfFrame pulse.
- Total drop duration: ceil((TARGET_Y-START_Y)/DROP_SPEED) frames.
- Blink phase duration: BLINK_FRAMES × BLINK_TOGGLES frames.
- Key edge at cycle N -> restartReq high for cycle N+1 only -> IDLE in cycle N+2.
- resetN low at any clock edge, in any state, forces the reset values on that edge. No partial sequence survives a reset.
- If startOfFrame and the state-entry event occur in the same cycle, the transition takes priority. That frame pulse is not counted in the new state.

## Configuration

- Macro: GAME_OVER_BLINK_EN.
- Defined: BLINK state is present, as described above.
- Undefined:
  - BLINK is compiled out.
  - DROP goes straight to WAIT_KEY when TARGET_Y is reached; show stays 1.
  - frameCnt and toggleCnt are not instantiated.

## Structure

- Package game_over_pkg holds:
  - the state enum (typedef, 3-bit);
  - the coordinate width constant (11);
  - the default screen constants (640×480, sprite size 32).
- Sub-module key_rise_detect: one register plus AND-NOT, synchronous active-low reset. It produces the single-cycle press pulse from restartKey.

## Test plan

- Reset check: hold resetN = 0 for 3 cycles -> topLeftY = 0, show = 0, gameFreeze = 0, restartReq = 0.
- Drop, default parameters: playerDead pulse, then 56 startOfFrame pulses -> topLeftY goes 4, 8, …, 224; the state enters BLINK after pulse 56.
- Drop clamp: DROP_SPEED = 5 -> topLeftY = 220 after 44 frames, clamps to 224 at frame 45, and never exceeds 224.
- Blink with the macro defined: show toggles every 15 frames, 6 toggles in total (90 frames), ends at 1, then WAIT_KEY.
- Held key: restartKey = 1 before WAIT_KEY is entered -> no restartReq. Release then press -> restartReq is exactly one cycle wide, and IDLE with show = 0 follows one cycle later.
- Reset during BLINK, plus macro off:
  - resetN = 0 mid-blink -> all outputs return to reset values on the next edge.
  - Rebuilt with the macro undefined, frame 56 -> WAIT_KEY directly, with show constantly 1.
